// File: rtl/rv64_decode_exec.sv
// RV64I decode-and-execute stage: decoder, keyed default mux and 64-bit ALU,
// with all results registered for one-cycle latency to write-back, fetch and LSU.

package rv64_decode_exec_pkg;
   typedef enum logic [3:0] {
      T_R     = 4'b0000,
      T_IALU  = 4'b0001,
      T_AUIPC = 4'b0010,
      T_B     = 4'b0011,
      T_S     = 4'b0100,
      T_LUI   = 4'b0101,
      T_LOAD  = 4'b1001,
      T_JALR  = 4'b1010,
      T_JAL   = 4'b1011,
      T_ILL   = 4'b1111
   } itype_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
   } aluop_e;
endpackage

module rv64_decode_exec_dec
   import rv64_decode_exec_pkg::*;
(
   input  logic [31:0] instr_i,
   output itype_e      type_o,
   output logic [63:0] imm_o,
   output aluop_e      alu_op_o,
   output logic        is_w_o
);
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign is_w_o = (opcode == 7'b0111011) || (opcode == 7'b0011011);

   assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
   assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
   assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
   assign imm_j = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

   always_comb begin
      type_o = T_ILL;
      case (opcode)
         7'b0110011, 7'b0111011: type_o = T_R;
         7'b0010011, 7'b0011011: type_o = T_IALU;
         7'b0010111:             type_o = T_AUIPC;
         7'b0110111:             type_o = T_LUI;
         7'b1100011:             type_o = T_B;
         7'b0100011:             type_o = T_S;
         7'b0000011:             type_o = T_LOAD;
         7'b1101111:             type_o = T_JAL;
         7'b1100111:             type_o = T_JALR;
         default:                type_o = T_ILL;
      endcase
   end

   always_comb begin
      imm_o = '0;
      case (type_o)
         T_IALU, T_LOAD, T_JALR: imm_o = imm_i;
         T_S:                    imm_o = imm_s;
         T_B:                    imm_o = imm_b;
         T_AUIPC, T_LUI:         imm_o = imm_u;
         T_JAL:                  imm_o = imm_j;
         default:                imm_o = '0;
      endcase
   end

   // Only R and I-ALU decode funct3; everything else computes an address-style add.
   always_comb begin
      alu_op_o = OP_ADD;
      if (type_o == T_R || type_o == T_IALU) begin
         case (funct3)
            3'b000: begin
               if (type_o == T_R && instr_i[30]) alu_op_o = OP_SUB;
               else                              alu_op_o = OP_ADD;
            end
            3'b001: alu_op_o = OP_SLL;
            3'b010: alu_op_o = OP_SLT;
            3'b011: alu_op_o = OP_SLTU;
            3'b100: alu_op_o = OP_XOR;
            3'b101: begin
               if (instr_i[30]) alu_op_o = OP_SRA;
               else             alu_op_o = OP_SRL;
            end
            3'b110: alu_op_o = OP_OR;
            default: alu_op_o = OP_AND;
         endcase
      end
   end
endmodule

module rv64_decode_exec_kmux #(
   parameter int unsigned N  = 2,
   parameter int unsigned KW = 4,
   parameter int unsigned DW = 64
) (
   input  logic [KW-1:0]        sel_i,
   input  logic [N-1:0][KW-1:0] keys_i,
   input  logic [N-1:0][DW-1:0] vals_i,
   input  logic [DW-1:0]        dflt_i,
   output logic [DW-1:0]        y_o
);
   logic found;

   always_comb begin
      y_o   = dflt_i;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && keys_i[i] == sel_i) begin
            y_o   = vals_i[i];
            found = 1'b1;
         end
      end
   end
endmodule

module rv64_decode_exec_alu
   import rv64_decode_exec_pkg::*;
(
   input  aluop_e      op_i,
   input  logic        w_i,
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   output logic [63:0] y_o
);
   logic [63:0] r64;
   logic [31:0] a32, b32, r32;
   logic [5:0]  sh64;
   logic [4:0]  sh32;

   assign a32  = a_i[31:0];
   assign b32  = b_i[31:0];
   assign sh64 = b_i[5:0];
   assign sh32 = b_i[4:0];

   always_comb begin
      r64 = '0;
      r32 = '0;
      case (op_i)
         OP_ADD:  begin r64 = a_i + b_i;            r32 = a32 + b32;            end
         OP_SUB:  begin r64 = a_i - b_i;            r32 = a32 - b32;            end
         OP_SLL:  begin r64 = a_i << sh64;          r32 = a32 << sh32;          end
         OP_SLT:  begin
            r64 = {63'd0, $signed(a_i) < $signed(b_i)};
            r32 = {31'd0, $signed(a32) < $signed(b32)};
         end
         OP_SLTU: begin r64 = {63'd0, a_i < b_i};   r32 = {31'd0, a32 < b32};   end
         OP_XOR:  begin r64 = a_i ^ b_i;            r32 = a32 ^ b32;            end
         OP_SRL:  begin r64 = a_i >> sh64;          r32 = a32 >> sh32;          end
         OP_SRA:  begin r64 = $signed(a_i) >>> sh64; r32 = $signed(a32) >>> sh32; end
         OP_OR:   begin r64 = a_i | b_i;            r32 = a32 | b32;            end
         OP_AND:  begin r64 = a_i & b_i;            r32 = a32 & b32;            end
         default: begin r64 = '0;                   r32 = '0;                   end
      endcase
      y_o = w_i ? {{32{r32[31]}}, r32} : r64;
   end
endmodule

module rv64_decode_exec
   import rv64_decode_exec_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic [4:0]      rs1_idx,
   output logic [4:0]      rs2_idx,
   output logic            out_valid,
   output logic [4:0]      rd_idx,
   output logic            wb_en,
   output logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] next_pc,
   output logic            load_en,
   output logic            store_en,
   output logic [2:0]      mem_funct3,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic            illegal
);
   itype_e            itype;
   aluop_e            alu_op;
   logic              is_w;
   logic [XLEN-1:0]   imm, op_a, op_b, alu_y, pc_plus4, jalr_sum;
   logic [2:0]        funct3;
   logic [4:0]        rd;
   logic              taken;
   logic [2:0][3:0]   a_keys;
   logic [2:0][XLEN-1:0] a_vals;
   logic [6:0][3:0]   b_keys;
   logic [6:0][XLEN-1:0] b_vals;

   logic            out_valid_q, wb_en_q, wb_en_d, load_en_q, store_en_q, illegal_q;
   logic [4:0]      rd_idx_q;
   logic [2:0]      mem_funct3_q;
   logic [XLEN-1:0] wb_data_q, wb_data_d, next_pc_q, next_pc_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign funct3  = instr[14:12];
   assign rd      = instr[11:7];

   rv64_decode_exec_dec u_dec (
      .instr_i  (instr),
      .type_o   (itype),
      .imm_o    (imm),
      .alu_op_o (alu_op),
      .is_w_o   (is_w)
   );

   assign a_keys[0] = T_AUIPC;  assign a_vals[0] = pc;
   assign a_keys[1] = T_JAL;    assign a_vals[1] = pc;
   assign a_keys[2] = T_LUI;    assign a_vals[2] = '0;

   rv64_decode_exec_kmux #(.N(3), .KW(4), .DW(XLEN)) u_mux_a (
      .sel_i  (itype),
      .keys_i (a_keys),
      .vals_i (a_vals),
      .dflt_i (rs1_data),
      .y_o    (op_a)
   );

   assign b_keys[0] = T_IALU;   assign b_vals[0] = imm;
   assign b_keys[1] = T_AUIPC;  assign b_vals[1] = imm;
   assign b_keys[2] = T_LUI;    assign b_vals[2] = imm;
   assign b_keys[3] = T_S;      assign b_vals[3] = imm;
   assign b_keys[4] = T_LOAD;   assign b_vals[4] = imm;
   assign b_keys[5] = T_JAL;    assign b_vals[5] = imm;
   assign b_keys[6] = T_JALR;   assign b_vals[6] = imm;

   rv64_decode_exec_kmux #(.N(7), .KW(4), .DW(XLEN)) u_mux_b (
      .sel_i  (itype),
      .keys_i (b_keys),
      .vals_i (b_vals),
      .dflt_i (rs2_data),
      .y_o    (op_b)
   );

   rv64_decode_exec_alu u_alu (
      .op_i (alu_op),
      .w_i  (is_w),
      .a_i  (op_a),
      .b_i  (op_b),
      .y_o  (alu_y)
   );

   assign pc_plus4   = pc + 64'd4;
   assign jalr_sum   = rs1_data + imm;
   assign mem_addr_d = rs1_data + imm;

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_data == rs2_data);
         3'b001:  taken = (rs1_data != rs2_data);
         3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  taken = (rs1_data <  rs2_data);
         3'b111:  taken = (rs1_data >= rs2_data);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      next_pc_d = pc_plus4;
      if (itype == T_JAL || (itype == T_B && taken)) next_pc_d = pc + imm;
      else if (itype == T_JALR)                     next_pc_d = {jalr_sum[XLEN-1:1], 1'b0};

      wb_data_d = alu_y;
      if (itype == T_JAL || itype == T_JALR) wb_data_d = pc_plus4;

      wb_en_d = 1'b0;
      case (itype)
         T_R, T_IALU, T_AUIPC, T_LUI, T_LOAD, T_JAL, T_JALR: wb_en_d = (rd != 5'd0);
         default: wb_en_d = 1'b0;
      endcase

      case (funct3[1:0])
         2'b00:   mem_wdata_d = {56'd0, rs2_data[7:0]};
         2'b01:   mem_wdata_d = {48'd0, rs2_data[15:0]};
         2'b10:   mem_wdata_d = {32'd0, rs2_data[31:0]};
         default: mem_wdata_d = rs2_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q  <= 1'b0;
         rd_idx_q     <= '0;
         wb_en_q      <= 1'b0;
         wb_data_q    <= '0;
         next_pc_q    <= '0;
         load_en_q    <= 1'b0;
         store_en_q   <= 1'b0;
         mem_funct3_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         illegal_q    <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            rd_idx_q     <= rd;
            wb_en_q      <= wb_en_d;
            wb_data_q    <= wb_data_d;
            next_pc_q    <= next_pc_d;
            load_en_q    <= (itype == T_LOAD);
            store_en_q   <= (itype == T_S);
            mem_funct3_q <= funct3;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            illegal_q    <= (itype == T_ILL);
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign rd_idx     = rd_idx_q;
   assign wb_en      = wb_en_q;
   assign wb_data    = wb_data_q;
   assign next_pc    = next_pc_q;
   assign load_en    = load_en_q;
   assign store_en   = store_en_q;
   assign mem_funct3 = mem_funct3_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign illegal    = illegal_q;
endmodule

// File: tb/tb_rv64_decode_exec.sv
// Directed bench for rv64_decode_exec: an instruction-level reference model
// checked every cycle, plus literal expectations from hand-decoded instructions.

module tb_rv64_decode_exec;
   localparam logic [6:0] O_R = 7'h33, O_RW = 7'h3B, O_I = 7'h13, O_IW = 7'h1B;
   localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JAL = 7'h6F, O_JALR = 7'h67;
   localparam logic [6:0] O_BR = 7'h63, O_LD = 7'h03, O_ST = 7'h23;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [63:0] pc = '0, rs1_data = '0, rs2_data = '0;
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic        out_valid, wb_en, load_en, store_en, illegal;
   logic [63:0] wb_data, next_pc, mem_addr, mem_wdata;
   logic [2:0]  mem_funct3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv64_decode_exec #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .out_valid(out_valid), .rd_idx(rd_idx), .wb_en(wb_en), .wb_data(wb_data),
      .next_pc(next_pc), .load_en(load_en), .store_en(store_en),
      .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .illegal(illegal)
   );

   typedef struct packed {
      logic [63:0] wb_data, next_pc, mem_addr, mem_wdata;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        wb_en, load_en, store_en, illegal;
      logic        c_wb, c_addr, c_wdata;
   } exp_t;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [63:0] alu_m(logic [2:0] f3, logic alt, logic w,
                                         logic [63:0] a, logic [63:0] b);
      logic [63:0] r;
      logic [31:0] x, y, q;
      r = '0;
      q = '0;
      x = a[31:0];
      y = b[31:0];
      if (!w) begin
         case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[5:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: r = (a < b) ? 64'd1 : 64'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               if (alt) r = $signed(a) >>> b[5:0];
               else     r = a >> b[5:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
         return r;
      end
      case (f3)
         3'd0: q = alt ? x - y : x + y;
         3'd1: q = x << y[4:0];
         3'd2: q = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: q = (x < y) ? 32'd1 : 32'd0;
         3'd4: q = x ^ y;
         3'd5: begin
            if (alt) q = $signed(x) >>> y[4:0];
            else     q = x >> y[4:0];
         end
         3'd6: q = x | y;
         default: q = x & y;
      endcase
      return {{32{q[31]}}, q};
   endfunction

   function automatic exp_t model(logic [31:0] ins, logic [63:0] p, logic [63:0] a, logic [63:0] b);
      exp_t e;
      logic [2:0] f3;
      logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm, mask;
      logic wr, tk;
      f3    = ins[14:12];
      i_imm = {{52{ins[31]}}, ins[31:20]};
      s_imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      b_imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      u_imm = {{32{ins[31]}}, ins[31:12], 12'h000};
      j_imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e = '0;
      e.rd = ins[11:7];
      e.f3 = f3;
      e.next_pc = p + 64'd4;
      wr = 1'b0;
      case (ins[6:0])
         O_R:     begin wr = 1; e.wb_data = alu_m(f3, ins[30], 1'b0, a, b); end
         O_RW:    begin wr = 1; e.wb_data = alu_m(f3, ins[30], 1'b1, a, b); end
         O_I:     begin wr = 1; e.wb_data = alu_m(f3, f3 == 3'd5 && ins[30], 1'b0, a, i_imm); end
         O_IW:    begin wr = 1; e.wb_data = alu_m(f3, f3 == 3'd5 && ins[30], 1'b1, a, i_imm); end
         O_LUI:   begin wr = 1; e.wb_data = u_imm; end
         O_AUIPC: begin wr = 1; e.wb_data = p + u_imm; end
         O_JAL:   begin wr = 1; e.wb_data = p + 64'd4; e.next_pc = p + j_imm; end
         O_JALR:  begin wr = 1; e.wb_data = p + 64'd4; e.next_pc = (a + i_imm) & ~64'd1; end
         O_BR: begin
            case (f3)
               3'd0: tk = (a == b);
               3'd1: tk = (a != b);
               3'd4: tk = $signed(a) < $signed(b);
               3'd5: tk = $signed(a) >= $signed(b);
               3'd6: tk = a < b;
               3'd7: tk = a >= b;
               default: tk = 1'b0;
            endcase
            if (tk) e.next_pc = p + b_imm;
         end
         O_LD: begin
            wr = 1; e.load_en = 1; e.c_addr = 1; e.mem_addr = a + i_imm;
         end
         O_ST: begin
            e.store_en = 1; e.c_addr = 1; e.c_wdata = 1; e.mem_addr = a + s_imm;
            mask = (f3[1:0] == 2'd0) ? 64'hFF : (f3[1:0] == 2'd1) ? 64'hFFFF :
                   (f3[1:0] == 2'd2) ? 64'hFFFF_FFFF : '1;
            e.mem_wdata = b & mask;
         end
         default: e.illegal = 1;
      endcase
      e.c_wb  = wr && ins[6:0] != O_LD;
      e.wb_en = wr && e.rd != 5'd0;
      return e;
   endfunction

   initial begin : compare
      exp_t e;
      logic ev;
      e = '0;
      ev = 1'b0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            e = '0; e.c_wb = 1; e.c_addr = 1; e.c_wdata = 1; ev = 1'b0;
         end else if (in_valid) begin
            e = model(instr, pc, rs1_data, rs2_data); ev = 1'b1;
         end else begin
            ev = 1'b0;
         end
         #1;
         chk("out_valid", 64'(out_valid), 64'(ev));
         chk("rd_idx", 64'(rd_idx), 64'(e.rd));
         chk("wb_en", 64'(wb_en), 64'(e.wb_en));
         chk("load_en", 64'(load_en), 64'(e.load_en));
         chk("store_en", 64'(store_en), 64'(e.store_en));
         chk("illegal", 64'(illegal), 64'(e.illegal));
         chk("mem_funct3", 64'(mem_funct3), 64'(e.f3));
         chk("next_pc", next_pc, e.next_pc);
         if (e.c_wb)    chk("wb_data", wb_data, e.wb_data);
         if (e.c_addr)  chk("mem_addr", mem_addr, e.mem_addr);
         if (e.c_wdata) chk("mem_wdata", mem_wdata, e.mem_wdata);
         chk("rs1_idx", 64'(rs1_idx), 64'(instr[19:15]));
         chk("rs2_idx", 64'(rs2_idx), 64'(instr[24:20]));
      end
   end

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                         logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
      return {f7, r2, r1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] r1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
      return {im, r1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
      return {im[11:5], r2, r1, f3, im[4:0], O_ST};
   endfunction
   function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] r2, logic [4:0] r1, logic [2:0] f3);
      return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], O_BR};
   endfunction
   function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
      return {im[20], im[10:1], im[11], im[19:12], rd, O_JAL};
   endfunction

   task automatic drive(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                        input logic [63:0] b);
      @(negedge clk);
      instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
   endtask

   initial begin : stim
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      drive(32'h00500093, 64'h8000_0000, 64'd0, 64'd0);
      chk("lit_addi_wb", wb_data, 64'd5);
      chk("lit_addi_rd", 64'(rd_idx), 64'd1);
      chk("lit_addi_wben", 64'(wb_en), 64'd1);
      chk("lit_addi_npc", next_pc, 64'h8000_0004);
      chk("lit_addi_valid", 64'(out_valid), 64'd1);
      drive(32'h40208133, 64'h8000_0004, 64'd3, 64'd5);
      chk("lit_sub_wb", wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("lit_sub_wben", 64'(wb_en), 64'd1);
      drive(32'h00000463, 64'h8000_0000, 64'd0, 64'd0);
      chk("lit_beq_taken", next_pc, 64'h8000_0008);
      chk("lit_beq_wben", 64'(wb_en), 64'd0);
      drive(32'h00000463, 64'h8000_0000, 64'd0, 64'd1);
      chk("lit_beq_not", next_pc, 64'h8000_0004);
      drive(32'h010000EF, 64'h8000_0000, 64'd0, 64'd0);
      chk("lit_jal_wb", wb_data, 64'h8000_0004);
      chk("lit_jal_npc", next_pc, 64'h8000_0010);
      chk("lit_jal_wben", 64'(wb_en), 64'd1);
      drive(32'h0010809B, 64'h8000_0000, 64'h7FFF_FFFF, 64'd0);
      chk("lit_addiw", wb_data, 64'hFFFF_FFFF_8000_0000);
      drive(32'h0000007F, 64'h1000, 64'd9, 64'd9);
      chk("lit_ill", 64'(illegal), 64'd1);
      chk("lit_ill_wben", 64'(wb_en), 64'd0);
      chk("lit_ill_npc", next_pc, 64'h1004);
      idle();
      chk("lit_hold_valid", 64'(out_valid), 64'd0);
      chk("lit_hold_npc", next_pc, 64'h1004);

      // asynchronous reset between edges, then an edge with reset still low
      drive(enc_i(12'h123, 5'd1, 3'd0, 5'd7, O_I), 64'h2000, 64'd1, 64'd0);
      rst = 1'b0;
      #1;
      chk("lit_rst_valid", 64'(out_valid), 64'd0);
      chk("lit_rst_wb", wb_data, 64'd0);
      chk("lit_rst_npc", next_pc, 64'd0);
      chk("lit_rst_rd", 64'(rd_idx), 64'd0);
      chk("lit_rst_wben", 64'(wb_en), 64'd0);
      drive(enc_i(12'h123, 5'd1, 3'd0, 5'd7, O_I), 64'h2000, 64'd1, 64'd0);
      chk("lit_rst_hold_valid", 64'(out_valid), 64'd0);
      chk("lit_rst_hold_npc", next_pc, 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;

      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, O_R), 64'h100, 64'd5, 64'd7);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3, O_R), 64'h104, 64'd1, 64'd65);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3, O_R), 64'h108, '1, 64'd1);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3, O_R), 64'h10C, '1, 64'd1);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3, O_R), 64'h110, 64'hF0F0, 64'hFF00);
      idle();
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3, O_R), 64'h114, 64'h8000_0000_0000_0000, 64'd4);
      drive(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, O_R), 64'h118, 64'h8000_0000_0000_0000, 64'd4);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3, O_R), 64'h11C, 64'h0F, 64'hF0);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3, O_R), 64'h120, 64'h3C, 64'h0F);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4, O_RW), 64'h124, 64'h7FFF_FFFF, 64'd1);
      drive(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, O_RW), 64'h128, 64'd0, 64'd1);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd4, O_RW), 64'h12C, 64'd1, 64'd63);
      drive(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd4, O_RW), 64'h130, 64'hFFFF_FFFF_8000_0000, 64'd4);
      drive(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd4, O_RW), 64'h134, 64'hFFFF_FFFF_8000_0000, 64'd4);
      idle();
      drive(enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, O_I), 64'h200, 64'd0, 64'd3);
      drive(enc_i(12'h800, 5'd1, 3'd2, 5'd5, O_I), 64'h204, 64'd0, 64'd3);
      drive(enc_i(12'hFFF, 5'd1, 3'd3, 5'd5, O_I), 64'h208, 64'd5, 64'd3);
      drive(enc_i(12'h0FF, 5'd1, 3'd4, 5'd5, O_I), 64'h20C, 64'h1234, 64'd0);
      drive(enc_i(12'h03F, 5'd1, 3'd1, 5'd5, O_I), 64'h210, 64'd1, 64'd0);
      drive(enc_i(12'h43F, 5'd1, 3'd5, 5'd5, O_I), 64'h214, 64'h8000_0000_0000_0000, 64'd0);
      drive(enc_i(12'h404, 5'd1, 3'd0, 5'd5, O_I), 64'h218, 64'd10, 64'd0);
      drive(enc_i(12'h01F, 5'd1, 3'd1, 5'd5, O_IW), 64'h21C, 64'd1, 64'd0);
      drive(enc_i(12'h41F, 5'd1, 3'd5, 5'd5, O_IW), 64'h220, 64'h8000_0000, 64'd0);
      drive(enc_i(12'h001, 5'd1, 3'd0, 5'd0, O_I), 64'h224, 64'd7, 64'd0);
      drive({20'h80000, 5'd6, O_LUI}, 64'h228, 64'd77, 64'd0);
      drive({20'h00001, 5'd6, O_AUIPC}, 64'h1000, 64'd77, 64'd0);
      drive(enc_i(12'hFF8, 5'd1, 3'd3, 5'd8, O_LD), 64'h300, 64'h1000, 64'd0);
      drive(enc_i(12'h010, 5'd1, 3'd4, 5'd0, O_LD), 64'h304, 64'h2000, 64'd0);
      for (int unsigned k = 0; k < 4; k++)
         drive(enc_s(12'hFFC, 5'd2, 5'd1, 3'(k)), 64'h308, 64'h4000, 64'h1122_3344_5566_7788);
      drive(enc_b(13'h1FF0, 5'd2, 5'd1, 3'd1), 64'h400, 64'd1, 64'd2);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd1), 64'h400, 64'd2, 64'd2);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd4), 64'h400, '1, 64'd0);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd5), 64'h400, '1, 64'd0);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd6), 64'h400, '1, 64'd0);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd7), 64'h400, '1, 64'd0);
      drive(enc_b(13'h0010, 5'd2, 5'd1, 3'd2), 64'h400, 64'd0, 64'd0);
      drive(enc_j(21'h1FFFF8, 5'd1), 64'h500, 64'd0, 64'd0);
      drive(enc_j(21'h000100, 5'd0), 64'h500, 64'd0, 64'd0);
      drive(enc_i(12'h002, 5'd1, 3'd0, 5'd1, O_JALR), 64'h600, 64'h1001, 64'd0);
      drive(enc_i(12'hFFF, 5'd1, 3'd0, 5'd1, O_JALR), 64'h600, 64'h1000, 64'd0);
      drive(32'h0000000F, 64'h700, 64'd1, 64'd2);
      drive(32'hFFFFFFFF, 64'h704, 64'd1, 64'd2);
      drive(enc_i(12'h001, 5'd1, 3'd0, 5'd1, O_I), 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0);
      chk("lit_pc_wrap", next_pc, 64'd0);

      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv64_decode_exec.md
Name: rv64_decode_exec

Overview:
- Single-issue RV64I decode-and-execute stage: takes a fetched instruction, PC and register-file read data, and produces write-back data, next PC and memory request.
- Internally built from three pieces: an instruction decoder (field split, immediate generation, type classification), a keyed default multiplexer for operand and result selection, and a 64-bit ALU.
- Results are registered: one-cycle latency to the write-back, fetch and LSU logic.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  instr/pc/rs data valid this cycle.
- instr  input  32  instruction word.
- pc  input  64  PC of instr.
- rs1_data  input  64  register-file read data for rs1_idx.
- rs2_data  input  64  register-file read data for rs2_idx.
- rs1_idx  output  5  instr[19:15], combinational.
- rs2_idx  output  5  instr[24:20], combinational.
- out_valid  output  1  registered outputs valid.
- rd_idx  output  5  destination register.
- wb_en  output  1  register write enable; forced 0 when rd_idx==0.
- wb_data  output  64  write-back data for non-load instructions.
- next_pc  output  64  PC of the following instruction.
- load_en  output  1  load request.
- store_en  output  1  store request.
- mem_funct3  output  3  access size/sign, taken from funct3.
- mem_addr  output  64  rs1 + imm.
- mem_wdata  output  64  rs2, zero-extended from the size given by funct3 (sb 8, sh 16, sw 32, sd 64 bits).
- illegal  output  1  unsupported opcode.

Behaviour:
- Type code (4 bits, internal), selected by opcode:
  - 0000 R: 0110011, 0111011.
  - 0001 I-ALU: 0010011, 0011011.
  - 0010 AUIPC: 0010111.
  - 0101 LUI: 0110111.
  - 0011 B: 1100011.
  - 0100 S: 0100011.
  - 1001 LOAD: 0000011.
  - 1011 JAL: 1101111.
  - 1010 JALR: 1100111.
  - 1111 otherwise.
- Immediates are sign-extended to 64 bits in the standard I/S/B/U/J formats; U-type is instr[31:12]<<12, sign-extended from bit 31.
- Operand A:
  - pc for AUIPC and JAL.
  - 0 for LUI.
  - rs1_data otherwise.
- Operand B: imm for I-ALU, AUIPC, LUI, S, LOAD, JAL, JALR; rs2_data for R and B.
- Both operand selections use the keyed mux with default (default is rs1_data / rs2_data respectively).
- ALU ops are selected by funct3 plus instr[30]:
  - add/sub; sub only for R-type with instr[30]=1.
  - sll, slt, sltu, xor, srl/sra (instr[30]), or, and.
  - Shift amount is B[5:0]; for W ops it is B[4:0].
- W variants (opcodes 0111011 and 0011011): operate on the low 32 bits, then sign-extend bit 31 to 64.
- Non-ALU types (S, LOAD, AUIPC, LUI, JAL) use add.
- wb_data selection:
  - JAL/JALR: pc+4.
  - All others: ALU result.
- Branches, decided on rs1_data vs rs2_data: beq, bne, blt, bge (signed), bltu, bgeu (unsigned). funct3 010/011 never taken.
- next_pc:
  - Taken branch or JAL: pc+imm.
  - JALR: (rs1_data+imm) with bit 0 cleared.
  - Otherwise: pc+4.
  - Arithmetic wraps modulo 2^64.
- wb_en is 1 for R, I-ALU, AUIPC, LUI, LOAD, JAL, JALR when rd_idx≠0; 0 for B, S and illegal.
- Illegal instruction: illegal=1, wb_en=0, load_en=0, store_en=0, next_pc=pc+4.
- Registering: on rising clk with in_valid=1, all registered outputs capture and out_valid=1. With in_valid=0, out_valid←0 and the other registers hold.
- Reset (rst low, any time including mid-operation): all registered outputs go to 0 immediately; the registers capture nothing while rst is low. Capture resumes on the first clk edge after release.
- rs1_idx/rs2_idx are purely combinational from instr and are unaffected by reset.
- The keyed default mux: N key/value pairs. Output = the value whose key matches the select; if no key matches, the default. If several keys match, the lowest-index pair wins.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x80000000, rs1_data=0 -> next cycle: wb_data=5, rd_idx=1, wb_en=1, next_pc=0x80000004, out_valid=1.
- sub x2,x1,x2 (0x40208133), rs1_data=3, rs2_data=5 -> wb_data=0xFFFFFFFFFFFFFFFE, wb_en=1.
- beq x0,x0,8 (0x00000463), pc=0x80000000, rs1_data=rs2_data=0 -> next_pc=0x80000008, wb_en=0. Repeat with rs2_data=1 -> next_pc=0x80000004.
- jal x1,16 (0x010000EF), pc=0x80000000 -> wb_data=0x80000004, next_pc=0x80000010, wb_en=1.
- addiw x1,x1,1 (0x0010809B), rs1_data=0x7FFFFFFF -> wb_data=0xFFFFFFFF80000000.
- Drive a valid op, then pull rst low between clock edges -> all registered outputs read 0 before the next edge. Opcode 0x7F with rst high -> illegal=1, wb_en=0, next_pc=pc+4.
